// File: rtl/lap_recall.sv
// lap_recall: lap-record store and read-back engine for the stopwatch path.
// Stores up to DEPTH split times (centiseconds) and converts a recalled entry
// into hours/minutes/seconds/centiseconds with a repeated-subtraction FSM.
// Optional feature macro: LAP_DELTA_EN (convert per-lap deltas instead of
// cumulative split times; adds one DELTA cycle to every conversion).
module lap_recall #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned CW    = 24
) (
    input  logic          clockSignal,
    input  logic          reset,
    input  logic          lapValid,
    input  logic [CW-1:0] lapCount,
    input  logic          clearLaps,
    input  logic          recallNext,
    output logic [3:0]    lapsStored,
    output logic          overflow,
    output logic          recallActive,
    output logic [3:0]    lapNumber,
    output logic [4:0]    hoursDisplay,
    output logic [5:0]    minutesDisplay,
    output logic [5:0]    secondsDisplay,
    output logic [6:0]    centisecondsDisplay,
    output logic          displayValid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DELTA,
        S_HRS,
        S_MIN,
        S_SEC,
        S_SHOW
    } state_t;

    localparam logic [CW-1:0] C_MAX = CW'(8639999);
    localparam logic [CW-1:0] C_HR  = CW'(360000);
    localparam logic [CW-1:0] C_MN  = CW'(6000);
    localparam logic [CW-1:0] C_SC  = CW'(100);

    logic [CW-1:0] r_store [DEPTH];
    logic          r_recallPrev;
    logic          r_edge;
    state_t        r_state;
    logic [3:0]    r_selIdx;
    logic [CW-1:0] r_work;
    logic [4:0]    r_h;
    logic [5:0]    r_m;
    logic [5:0]    r_s;

    logic          w_full;
    logic          w_accept;
    logic [3:0]    w_nextIdx;
    logic [CW-1:0] w_entry;

    function automatic logic [CW-1:0] f_sat(input logic [CW-1:0] v);
        return (v > C_MAX) ? C_MAX : v;
    endfunction

    assign w_full    = (lapsStored == 4'(DEPTH));
    // lapNumber is 1-based, so it already names the next 0-based entry
    assign w_nextIdx = (lapNumber < lapsStored) ? lapNumber : '0;
    assign w_accept  = r_edge && (lapsStored != '0) &&
                       ((r_state == S_IDLE) || (r_state == S_SHOW));
    assign w_entry   = r_store[r_selIdx];

`ifdef LAP_DELTA_EN
    logic [CW-1:0] r_sub;
    logic [3:0]    w_prevIdx;
    logic [CW-1:0] w_prevEntry;
    assign w_prevIdx   = (r_selIdx == '0) ? '0 : (r_selIdx - 4'd1);
    assign w_prevEntry = (r_selIdx == '0) ? '0 : r_store[w_prevIdx];
`endif

    // Store array: plain RAM-style write, contents need no reset
    always_ff @(posedge clockSignal) begin
        if (lapValid && !clearLaps && !w_full) begin
            r_store[lapsStored] <= lapCount;
        end
    end

    // Write-side bookkeeping: entry count and sticky overflow
    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            lapsStored <= '0;
            overflow   <= 1'b0;
        end else if (clearLaps) begin
            lapsStored <= '0;
            overflow   <= 1'b0;
        end else if (lapValid) begin
            if (w_full) begin
                overflow <= 1'b1;
            end else begin
                lapsStored <= lapsStored + 4'd1;
            end
        end
    end

    // Recall button rising-edge detector (registered one-cycle pulse)
    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            r_recallPrev <= 1'b0;
            r_edge       <= 1'b0;
        end else begin
            r_recallPrev <= recallNext;
            r_edge       <= recallNext & ~r_recallPrev;
        end
    end

    // Conversion FSM with registered display outputs
    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_selIdx            <= '0;
            r_work              <= '0;
            r_h                 <= '0;
            r_m                 <= '0;
            r_s                 <= '0;
            recallActive        <= 1'b0;
            lapNumber           <= '0;
            hoursDisplay        <= '0;
            minutesDisplay      <= '0;
            secondsDisplay      <= '0;
            centisecondsDisplay <= '0;
            displayValid        <= 1'b0;
`ifdef LAP_DELTA_EN
            r_sub               <= '0;
`endif
        end else if (clearLaps) begin
            r_state             <= S_IDLE;
            r_selIdx            <= '0;
            r_work              <= '0;
            r_h                 <= '0;
            r_m                 <= '0;
            r_s                 <= '0;
            recallActive        <= 1'b0;
            lapNumber           <= '0;
            hoursDisplay        <= '0;
            minutesDisplay      <= '0;
            secondsDisplay      <= '0;
            centisecondsDisplay <= '0;
            displayValid        <= 1'b0;
`ifdef LAP_DELTA_EN
            r_sub               <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_accept) begin
                        r_selIdx <= w_nextIdx;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_h          <= '0;
                    r_m          <= '0;
                    r_s          <= '0;
                    displayValid <= 1'b0;
                    lapNumber    <= r_selIdx + 4'd1;
                    recallActive <= 1'b1;
`ifdef LAP_DELTA_EN
                    r_work  <= w_entry;
                    r_sub   <= w_prevEntry;
                    r_state <= S_DELTA;
`else
                    r_work  <= f_sat(w_entry);
                    r_state <= S_HRS;
`endif
                end
`ifdef LAP_DELTA_EN
                S_DELTA: begin
                    // non-monotonic splits clamp to zero rather than wrap
                    r_work  <= (r_work >= r_sub) ? f_sat(r_work - r_sub) : '0;
                    r_state <= S_HRS;
                end
`endif
                S_HRS: begin
                    if (r_work >= C_HR) begin
                        r_work <= r_work - C_HR;
                        r_h    <= r_h + 5'd1;
                    end else begin
                        r_state <= S_MIN;
                    end
                end
                S_MIN: begin
                    if (r_work >= C_MN) begin
                        r_work <= r_work - C_MN;
                        r_m    <= r_m + 6'd1;
                    end else begin
                        r_state <= S_SEC;
                    end
                end
                S_SEC: begin
                    if (r_work >= C_SC) begin
                        r_work <= r_work - C_SC;
                        r_s    <= r_s + 6'd1;
                    end else begin
                        hoursDisplay        <= r_h;
                        minutesDisplay      <= r_m;
                        secondsDisplay      <= r_s;
                        centisecondsDisplay <= 7'(r_work);
                        displayValid        <= 1'b1;
                        r_state             <= S_SHOW;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lap_recall.md
# lap_recall

- Lap-record store and read-back engine for the stopwatch path.
- The stopwatch writes split times (elapsed centiseconds) into a 10-entry store. The user steps through them with the recall button.
- Each recalled entry is converted by a multi-cycle FSM into hours/minutes/seconds/centiseconds display fields.
- Sits between the timer core (writer) and the display drivers (consumer).

## Interface
Parameters:
- DEPTH, 10, number of lap entries (1..15)
- CW, 24, width of centisecond count

Ports:
- clockSignal  in  1  system clock, 100 Hz tick domain
- reset  in  1  asynchronous, active-high; clears all state
- lapValid  in  1  single-cycle write strobe from stopwatch
- lapCount  in  CW  elapsed centiseconds at the split, sampled when lapValid=1
- clearLaps  in  1  single-cycle pulse; empties the store
- recallNext  in  1  raw level from recall button; the block edge-detects it
- lapsStored  out  4  number of valid entries
- overflow  out  1  sticky; a write was attempted while full
- recallActive  out  1  high while a recalled entry is shown or converting
- lapNumber  out  4  1-based index of the shown entry; 0 when none
- hoursDisplay  out  5  converted hours
- minutesDisplay  out  6  converted minutes
- secondsDisplay  out  6  converted seconds
- centisecondsDisplay  out  7  converted centiseconds
- displayValid  out  1  display fields are stable and correct

## Operation
Write:
- lapValid with lapsStored<DEPTH stores lapCount at index lapsStored, then increments lapsStored.
- lapValid when full: the write is dropped and overflow is set.
- clearLaps zeroes lapsStored and overflow, and forces the read side to IDLE. All outputs return to their reset values.
- clearLaps and lapValid in the same cycle: clear wins and the write is dropped.

Recall:
- A rising edge is recallNext=1 now and 0 at the previous clockSignal edge.
- While lapsStored=0, a rising edge is ignored.
- The first edge after reset or clear selects entry 0. Each later edge selects the next entry, wrapping from lapsStored-1 back to 0.
- An edge while the FSM is not in IDLE/SHOW is dropped.
- If a write lands in the same cycle as an edge, the wrap decision uses the pre-write lapsStored.

Conversion FSM: IDLE -> LOAD -> HRS -> MIN -> SEC -> SHOW; SHOW -> LOAD on the next accepted edge.
- LOAD:
  - Copies the entry into a working register and clears the digit counters.
  - Drops displayValid.
  - Updates lapNumber.
  - Sets recallActive.
  - Saturates the working value to 8639999 (23:59:59.99) if it is larger.
- HRS, MIN, SEC: each cycle, if working ≥ 360000 / 6000 / 100 respectively, subtract that constant and increment the digit. Otherwise advance to the next state.
- SHOW: the remainder goes to centisecondsDisplay, digits are latched to the outputs, and displayValid=1.

Arithmetic:
- Unsigned compares and subtracts at CW bits.
- Digit counters never exceed 23/59/59.

Reset values: every output 0; FSM in IDLE; store contents don't-care.

## Timing
- Write: lapsStored and overflow update on the clockSignal edge that samples lapValid.
- Recall latency: the edge is detected at edge E0 (LOAD entered at E0+1). displayValid rises at E0+h+m+s+5, where h/m/s are the resulting digits.
- Worst case is 23:59:59.xx, giving 146 cycles.
- Display fields change only when SHOW is entered; they hold until the next LOAD.
- displayValid is low from LOAD through SEC.
- Async reset mid-conversion: all outputs are 0 immediately, with no partial update.

## Configuration
- LAP_DELTA_EN defined:
  - LOAD converts entry[i] − entry[i−1], i.e. per-lap time, using entry[−1]=0.
  - A negative difference (non-monotonic input) saturates to 0.
  - Conversion takes one extra LOAD cycle, so latency becomes h+m+s+6.
- LAP_DELTA_EN undefined: the cumulative split time is converted as stored.

## Test plan
- Reset, write lapCount=372345, one recall edge -> lapNumber=1, displays 1/2/3/45, displayValid exactly 11 cycles after the edge.
- Write 10 laps, then an 11th -> lapsStored=10, overflow=1, 11th value absent; clearLaps -> lapsStored=0, overflow=0, displays 0.
- Write 3 laps (100, 250, 6100), 4 recall edges -> lapNumber 1,2,3,1; seconds/cs 1.00, 2.50, 1:01.00, 1.00.
- lapCount=16777215 -> saturates to 23/59/59/99 after 146 cycles; a recall edge mid-conversion is dropped and lapNumber is unchanged.
- Simultaneous clearLaps+lapValid -> lapsStored=0; async reset during HRS -> all outputs 0 the same cycle.
- With LAP_DELTA_EN: laps 500, 1200 -> second recall shows 0/0/7/00 at 13 cycles; laps 900, 400 -> second recall shows all zeros.
